// File: rtl/fetch.sv
// ucrv32 instruction fetch: owns the PC, issues in-order word requests and
// buffers returned words for decode, flushing everything on a redirect.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        n_rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   last_pc;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] out_next;
    logic          handshake;
    logic          resp_ok;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Buffered words plus in-flight requests never exceed DEPTH, so a push
    // always finds room without any backpressure on the memory side.
    always_comb begin
        imem_req_o  = n_rst && !redirect_i &&
                      (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
        imem_addr_o = fetch_pc & ALIGN;
        handshake   = imem_req_o && imem_gnt_i;
        resp_ok     = imem_rvalid_i && (outstanding != '0);
        push        = resp_ok && (discard == '0) && !redirect_i;
        valid_o     = (count != '0);
        pop         = valid_o && !stall_i;
        instruction_o = valid_o ? ins_mem[rd_ptr] : NOP;
        pc_o          = valid_o ? pc_mem[rd_ptr]  : last_pc;
    end

    always_comb begin
        out_next = outstanding;
        if (handshake && !resp_ok)
            out_next = outstanding + ONE;
        else if (!handshake && resp_ok)
            out_next = outstanding - ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            last_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= out_next;
            if (valid_o)
                last_pc <= pc_mem[rd_ptr];
            if (redirect_i) begin
                // Every request still in flight after this cycle is stale.
                fetch_pc <= redirect_pc_i & ALIGN;
                resp_pc  <= redirect_pc_i & ALIGN;
                discard  <= out_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (handshake)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp_ok) begin
                    if (discard != '0)
                        discard <= discard - ONE;
                    else
                        resp_pc <= resp_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= bump(wr_ptr);
                if (pop)
                    rd_ptr <= bump(rd_ptr);
                if (push && !pop)
                    count <= count + ONE;
                else if (!push && pop)
                    count <= count - ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]  <= resp_pc;
            ins_mem[wr_ptr] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: a latency-1 instruction memory, a queue-level model of the
// fetch stage checked every cycle, and hand-computed directed expectations.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .n_rst(n_rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .stall_i(stall), .valid_o(valid), .instruction_o(instr), .pc_o(pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- model ----------------
    typedef struct { logic [31:0] addr; bit stale; } fly_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    fly_t        m_fly[$];
    ent_t        m_fifo[$];
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_last  = RESET_PC;
    fly_t        m_r;
    bit          m_take;
    bit          m_hs;
    bit          m_ev;
    bit          chk_en = 1'b0;
    bit          hs_seen = 1'b0;
    logic [31:0] addr_seen = '0;

    function automatic bit m_req();
        return (n_rst === 1'b1) && (redirect !== 1'b1) &&
               ((m_fly.size() + m_fifo.size()) < DEPTH);
    endfunction

    always @(negedge clk) begin
        hs_seen   = (req === 1'b1) && (gnt === 1'b1);
        addr_seen = addr;
        if (chk_en) begin
            m_ev = (m_fifo.size() != 0);
            check("req", 32'(req), 32'(m_req()));
            if (m_req())
                check("addr", addr, m_fetch);
            check("valid", 32'(valid), 32'(m_ev));
            check("instr", instr, m_ev ? m_fifo[0].ins : NOP);
            check("pc", pc, m_ev ? m_fifo[0].pc : m_last);
        end
    end

    always @(posedge clk) begin
        if (n_rst !== 1'b1) begin
            m_fly.delete();
            m_fifo.delete();
            m_fetch = RESET_PC;
            m_last  = RESET_PC;
        end else begin
            m_hs = m_req() && (gnt === 1'b1);
            if (m_fifo.size() != 0)
                m_last = m_fifo[0].pc;
            m_take = 1'b0;
            if (rvalid === 1'b1 && m_fly.size() != 0) begin
                m_r    = m_fly.pop_front();
                m_take = !m_r.stale && (redirect !== 1'b1);
            end
            if (redirect === 1'b1) begin
                m_fifo.delete();
                foreach (m_fly[i]) m_fly[i].stale = 1'b1;
                m_fetch = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_fifo.size() != 0 && stall !== 1'b1)
                    void'(m_fifo.pop_front());
                if (m_take)
                    m_fifo.push_back('{pc: m_r.addr, ins: rdata});
                if (m_hs) begin
                    m_fly.push_back('{addr: m_fetch, stale: 1'b0});
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
    end

    // ---------------- stimulus / memory ----------------
    logic [31:0] pend[$];
    bit          from_pend = 1'b0;
    bit          k_rst, k_gnt, k_stall, k_redir, k_rsp, k_spur;
    logic [31:0] k_rpc;

    task automatic tick();
        @(posedge clk);
        if (from_pend) void'(pend.pop_front());
        if (hs_seen) pend.push_back(addr_seen);
        #1;
        n_rst       = k_rst;
        gnt         = k_gnt;
        stall       = k_stall;
        redirect    = k_redir;
        redirect_pc = k_rpc;
        from_pend   = 1'b0;
        if (k_spur) begin
            rvalid = 1'b1;
            rdata  = 32'hBAD0_BAD0;
        end else if (k_rsp && pend.size() != 0) begin
            rvalid    = 1'b1;
            rdata     = word_at(pend[0]);
            from_pend = 1'b1;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        k_redir = 1'b0;
        k_spur  = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; gnt = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; rvalid = 1'b0; rdata = '0;
        k_rst = 1'b0; k_gnt = 1'b1; k_stall = 1'b0; k_redir = 1'b0;
        k_rsp = 1'b1; k_spur = 1'b0; k_rpc = '0;

        tick();
        chk_en = 1'b1;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", pc, RESET_PC);
        check("rst_req", 32'(req), 32'd0);

        // stream from reset
        k_rst = 1'b1;
        tick(); #2;
        check("c0_req", 32'(req), 32'd1);
        check("c0_addr", addr, 32'h0);
        tick(); #2;
        check("c1_addr", addr, 32'h4);
        check("c1_valid", 32'(valid), 32'd0);
        tick(); #2;
        check("c2_valid", 32'(valid), 32'd1);
        check("c2_pc", pc, 32'h0);
        check("c2_instr", instr, word_at(32'h0));
        check("c2_req", 32'(req), 32'd0);
        tick(); #2;
        check("c3_pc", pc, 32'h4);
        check("c3_addr", addr, 32'h8);
        repeat (6) tick();

        // stall fills the FIFO and stops requests
        k_stall = 1'b1;
        repeat (5) tick();
        #2;
        check("stall_req", 32'(req), 32'd0);
        check("stall_valid", 32'(valid), 32'd1);
        tick();
        k_stall = 1'b0;
        repeat (8) tick();

        // grant withheld: drain, then address held with NOP output
        k_gnt = 1'b0;
        repeat (5) tick();
        #2;
        check("gw_valid", 32'(valid), 32'd0);
        check("gw_instr", instr, NOP);
        check("gw_req", 32'(req), 32'd1);
        repeat (3) tick();
        k_spur = 1'b1;
        tick();
        tick(); #2;
        check("spurious_valid", 32'(valid), 32'd0);

        // redirect with one request outstanding
        k_rsp = 1'b0; k_gnt = 1'b1;
        tick();
        k_gnt = 1'b0; k_redir = 1'b1; k_rpc = 32'h0000_0102;
        tick(); #2;
        check("redir_req", 32'(req), 32'd0);
        k_gnt = 1'b1; k_rsp = 1'b1;
        tick(); #2;
        check("r1_valid", 32'(valid), 32'd0);
        check("r1_addr", addr, 32'h100);
        tick(); #2;
        check("r2_valid", 32'(valid), 32'd0);
        // redirect together with an rvalid and a pop
        k_redir = 1'b1; k_rpc = 32'h0000_0200;
        tick(); #2;
        check("r3_valid", 32'(valid), 32'd1);
        check("r3_pc", pc, 32'h100);
        check("r3_instr", instr, word_at(32'h100));
        tick(); #2;
        check("r4_valid", 32'(valid), 32'd0);
        check("r4_pc", pc, 32'h100);
        check("r4_addr", addr, 32'h200);
        tick(); tick(); #2;
        check("r6_pc", pc, 32'h200);

        // address wrap
        k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC;
        tick();
        tick(); #2;
        check("w1_addr", addr, 32'hFFFF_FFFC);
        tick(); #2;
        check("w2_addr", addr, 32'h0000_0000);
        tick(); #2;
        check("w3_pc", pc, 32'hFFFF_FFFC);
        tick(); #2;
        check("w4_pc", pc, 32'h0000_0000);
        check("w4_instr", instr, word_at(32'h0));

        // reset mid-stream with responses still in flight
        repeat (4) tick();
        k_rsp = 1'b0;
        repeat (2) tick();
        k_rst = 1'b0;
        tick(); #2;
        check("mrst_req", 32'(req), 32'd0);
        k_rst = 1'b1; k_gnt = 1'b0; k_rsp = 1'b1;
        tick(); #2;
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_pc", pc, RESET_PC);
        check("mrst_instr", instr, NOP);
        repeat (3) tick();
        k_gnt = 1'b1;
        tick(); #2;
        check("mrst_addr", addr, RESET_PC);
        tick(); tick(); #2;
        check("mrst_first_pc", pc, RESET_PC);
        check("mrst_first_valid", 32'(valid), 32'd1);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
